// File: rtl/cursor_controller_pkg.sv
// Shared definitions for the cursor controller block.
// Holds the direction encodings, the default grid dimensions, the key-repeat
// FSM state encodings and the fixed-priority direction picker.
// Optional feature macro used by this block: CURSOR_AUTOREPEAT_EN.
package cursor_controller_pkg;

  // Direction encodings. The same value indexes the {left,down,right,up}
  // level vector, so bit DIR_x of that vector belongs to direction DIR_x.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Default tile grid dimensions.
  localparam int DEF_COLS = 8;
  localparam int DEF_ROWS = 8;

  // Key-repeat FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Fixed priority among simultaneous rises: up > right > down > left.
  function automatic logic [1:0] pick_dir(input logic [3:0] rise);
    logic [1:0] dir;
    if (rise[DIR_UP]) begin
      dir = DIR_UP;
    end else if (rise[DIR_RIGHT]) begin
      dir = DIR_RIGHT;
    end else if (rise[DIR_DOWN]) begin
      dir = DIR_DOWN;
    end else begin
      dir = DIR_LEFT;
    end
    return dir;
  endfunction

endpackage

// File: rtl/cursor_controller_key_repeat.sv
// key_repeat: edge detection, press arbitration and auto-repeat timing.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   level[3:0]      - debounced key levels, indexed by direction encoding
//   step            - combinational one-cycle move request
//   step_dir        - direction of the requested move
// With CURSOR_AUTOREPEAT_EN defined, a held key repeats after REPEAT_DELAY
// cycles and then every REPEAT_RATE cycles; otherwise only rises move.
module key_repeat
  import cursor_controller_pkg::*;
#(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] level,
  output logic       step,
  output logic [1:0] step_dir
);

  logic [3:0] prev_r;
  logic [3:0] rise_s;

  // Previous-sample register; loads the live levels during reset so a key
  // held through reset is not seen as a new press.
  always_ff @(posedge clk) begin
    prev_r <= level;
  end

  assign rise_s = level & ~prev_r;

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rep_state_t       state_r, nx_state_s;
  logic [CNT_W-1:0] cnt_r, nx_cnt_s;
  logic [1:0]       active_r, nx_active_s;
  logic [3:0]       rise_other_s;
  logic [CNT_W-1:0] last_s;

  // Rises on any direction other than the one being repeated can preempt.
  assign rise_other_s = rise_s & ~(4'b0001 << active_r);

  // FSM state, repeat counter and active-direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      active_r <= DIR_UP;
    end else begin
      state_r  <= nx_state_s;
      cnt_r    <= nx_cnt_s;
      active_r <= nx_active_s;
    end
  end

  // Next-state and step decode; preemption outranks release and expiry.
  always_comb begin
    nx_state_s  = state_r;
    nx_cnt_s    = cnt_r;
    nx_active_s = active_r;
    step        = 1'b0;
    step_dir    = active_r;
    last_s      = (state_r == ST_DELAY) ? DLY_LAST : RATE_LAST;
    case (state_r)
      ST_IDLE: begin
        if (|rise_s) begin
          step        = 1'b1;
          step_dir    = pick_dir(rise_s);
          nx_active_s = pick_dir(rise_s);
          nx_cnt_s    = CNT_ZERO;
          nx_state_s  = ST_DELAY;
        end else begin
          nx_cnt_s    = CNT_ZERO;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (|rise_other_s) begin
          step        = 1'b1;
          step_dir    = pick_dir(rise_other_s);
          nx_active_s = pick_dir(rise_other_s);
          nx_cnt_s    = CNT_ZERO;
          nx_state_s  = ST_DELAY;
        end else if (!level[active_r]) begin
          nx_cnt_s    = CNT_ZERO;
          nx_state_s  = ST_IDLE;
        end else if (cnt_r == last_s) begin
          step        = 1'b1;
          nx_cnt_s    = CNT_ZERO;
          nx_state_s  = ST_REPEAT;
        end else begin
          nx_cnt_s    = cnt_r + CNT_ONE;
        end
      end
      default: begin
        nx_cnt_s   = CNT_ZERO;
        nx_state_s = ST_IDLE;
      end
    endcase
  end
`else
  // Timing parameters have no effect without auto-repeat.
  logic [31:0] cfg_unused_s;
  assign cfg_unused_s = REPEAT_DELAY ^ REPEAT_RATE;

  // Without auto-repeat every rise moves once, with the same priority.
  always_comb begin
    step     = |rise_s;
    step_dir = pick_dir(rise_s);
  end
`endif

endmodule

// File: rtl/cursor_controller.sv
// cursor_controller: turns debounced direction keys into a wrapping cursor
// position on a COLS x ROWS tile grid.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   up, right, down, left - debounced key levels, 1 = pressed
//   cur_x, cur_y          - registered cursor column / row, (0,0) = top-left
//   move                  - one-cycle pulse when the cursor takes a new value
//   move_dir              - direction of the last move (00 up .. 11 left)
// Optional feature macro: CURSOR_AUTOREPEAT_EN (held-key auto-repeat).
module cursor_controller
  import cursor_controller_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      up,
  input  logic                      right,
  input  logic                      down,
  input  logic                      left,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y,
  output logic                      move,
  output logic [1:0]                move_dir
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_ZERO = XW'(0);
  localparam logic [YW-1:0] Y_ZERO = YW'(0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  logic          step_s;
  logic [1:0]    step_dir_s;
  logic [XW-1:0] nx_x_s;
  logic [YW-1:0] nx_y_s;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_repeat (
    .clk      (clk),
    .rst      (rst),
    .level    ({left, down, right, up}),
    .step     (step_s),
    .step_dir (step_dir_s)
  );

  // Wrapping single-step cursor arithmetic.
  always_comb begin
    nx_x_s = cur_x;
    nx_y_s = cur_y;
    case (step_dir_s)
      DIR_UP:    nx_y_s = (cur_y == Y_ZERO) ? Y_MAX  : cur_y - Y_ONE;
      DIR_DOWN:  nx_y_s = (cur_y == Y_MAX)  ? Y_ZERO : cur_y + Y_ONE;
      DIR_LEFT:  nx_x_s = (cur_x == X_ZERO) ? X_MAX  : cur_x - X_ONE;
      DIR_RIGHT: nx_x_s = (cur_x == X_MAX)  ? X_ZERO : cur_x + X_ONE;
      default: begin
        nx_x_s = cur_x;
        nx_y_s = cur_y;
      end
    endcase
  end

  // Output registers for position, move pulse and last direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x    <= X_ZERO;
      cur_y    <= Y_ZERO;
      move     <= 1'b0;
      move_dir <= DIR_UP;
    end else begin
      move <= step_s;
      if (step_s) begin
        cur_x    <= nx_x_s;
        cur_y    <= nx_y_s;
        move_dir <= step_dir_s;
      end
    end
  end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed self-checking bench for cursor_controller (8x8 grid, delay 4,
// rate 2). Expected values adapt to whether CURSOR_AUTOREPEAT_EN is defined.
module tb_cursor_controller;

`ifdef CURSOR_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0;
  logic [2:0] cur_x, cur_y;
  logic       move;
  logic [1:0] move_dir;

  int checks = 0;
  int errors = 0;
  int n_moves;

  cursor_controller #(
    .COLS(8), .ROWS(8), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .right(right), .down(down), .left(left),
    .cur_x(cur_x), .cur_y(cur_y), .move(move), .move_dir(move_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    tick();
    do_reset();
    check("rst_x", cur_x, 0);
    check("rst_y", cur_y, 0);
    check("rst_move", move, 0);
    check("rst_dir", move_dir, 0);

    // Single right pulse.
    right = 1'b1; tick();
    check("r_move", move, 1);
    check("r_dir", move_dir, 1);
    check("r_x", cur_x, 1);
    check("r_y", cur_y, 0);
    right = 1'b0; tick();
    check("r_move_end", move, 0);
    check("r_x_hold", cur_x, 1);

    // Wrap cases.
    do_reset();
    up = 1'b1; tick();
    check("up_wrap_y", cur_y, 7);
    check("up_wrap_dir", move_dir, 0);
    up = 1'b0; tick();
    left = 1'b1; tick();
    check("left_wrap_x", cur_x, 7);
    check("left_wrap_dir", move_dir, 3);
    left = 1'b0; tick();
    right = 1'b1; tick();
    check("right_wrap_x", cur_x, 0);
    right = 1'b0; tick();

    // Simultaneous up + left: up wins, x untouched.
    up = 1'b1; left = 1'b1; tick();
    check("prio_move", move, 1);
    check("prio_dir", move_dir, 0);
    check("prio_x", cur_x, 0);
    check("prio_y", cur_y, 6);
    up = 1'b0; left = 1'b0; tick();
    check("prio_single", move, 0);

    // Hold down for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      down = 1'b1; tick();
      check($sformatf("hold_dn_move_%0d", i), move,
            AR ? (i == 0 || i == 4 || i == 6 || i == 8) : (i == 0));
    end
    check("hold_dn_y", cur_y, AR ? 4 : 1);
    down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rel_dn_move_%0d", i), move, 0);
    end
    check("rel_dn_y", cur_y, AR ? 4 : 1);

    // Hold right, press down at cycle 5: down preempts.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      right = 1'b1;
      down  = (i >= 5);
      tick();
      check($sformatf("pre_move_%0d", i), move,
            AR ? (i == 0 || i == 4 || i == 5 || i == 9 || i == 11)
               : (i == 0 || i == 5));
      check($sformatf("pre_dir_%0d", i), move_dir, (i >= 5) ? 2 : 1);
    end
    check("pre_x", cur_x, AR ? 2 : 1);
    check("pre_y", cur_y, AR ? 3 : 1);
    right = 1'b0; down = 1'b0; tick();

    // Hold left for 20 cycles and count moves.
    do_reset();
    n_moves = 0;
    left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (move) n_moves++;
    end
    check("hold_left_count", n_moves, AR ? 9 : 1);
    left = 1'b0; tick();

    // Hold left through reset: suppressed until release and re-press.
    left = 1'b1; tick();
    do_reset();
    check("rsthold_x", cur_x, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rsthold_move_%0d", i), move, 0);
    end
    left = 1'b0; tick();
    check("rsthold_rel_move", move, 0);
    left = 1'b1; tick();
    check("rsthold_press_move", move, 1);
    check("rsthold_press_x", cur_x, 7);
    check("rsthold_press_dir", move_dir, 3);
    left = 1'b0; tick();

    // Reset mid-hold of down: cursor returns home, no further moves.
    down = 1'b1; tick();
    check("midrst_y_before", cur_y, 1);
    do_reset();
    check("midrst_x", cur_x, 0);
    check("midrst_y", cur_y, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("midrst_move_%0d", i), move, 0);
    end
    down = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
